// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SRAM between an instruction-fetch port and a data port.
// Each access runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (ready pulse) -> IDLE.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_q, last_d;   // 1 = data port was granted last
  logic                gnt_q, gnt_d;     // 1 = current access belongs to the data port
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                grant_data;

  // Byte offset and bits above the SRAM word address are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    // On a tie the data port wins only if the fetch port was granted last.
    grant_data = d_req & (~if_req | ~last_q);

    case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          state_d = ACCESS;
          cnt_d   = '0;
          gnt_d   = grant_data;
          last_d  = grant_data;
          addr_d  = grant_data ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
          wdata_d = d_wdata;
          we_d    = grant_data & d_we;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_q) d_rdata_d  = sram_rdata;
            else       if_rdata_d = sram_rdata;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sram_en    = (state_q == ACCESS);
  assign sram_we    = sram_en & we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign if_ready   = (state_q == DONE) & ~gnt_q;
  assign d_ready    = (state_q == DONE) & gnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions, a monitor checks each ready pulse.
module tb_mem_arbiter;

  localparam int unsigned WAIT   = 3;
  localparam int unsigned ADDR_W = 16;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              busy;

  logic              rd_mode;
  logic [31:0]       rd_word;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } sb_item_t;

  sb_item_t sb[$];
  int tests = 0;
  int fails = 0;
  int n_if  = 0;
  int n_d   = 0;
  logic [31:0] if_model;
  logic [31:0] d_model;

  mem_arbiter #(
    .WAIT_CYCLES(WAIT),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM stand-in: either a directed word or a word derived from the address.
  always_comb sram_rdata = rd_mode ? {16'hA5A5, sram_addr} : rd_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    sb_item_t it;
    if (if_ready === 1'b1 || d_ready === 1'b1) begin
      if (if_ready === 1'b1 && d_ready === 1'b1) begin
        tests++;
        fails++;
        $display("FAIL both_ready: if_ready=1 d_ready=1 required at most one");
      end else if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: if_ready=%b d_ready=%b required no pulse", if_ready, d_ready);
      end else begin
        it = sb.pop_front();
        chk("grant_port", {31'b0, d_ready}, {31'b0, it.is_data});
        chk("ready_rdata", it.is_data ? d_rdata : if_rdata, it.rdata);
        if (d_ready) n_d++;
        else         n_if++;
      end
    end
  end

  // Starts in an IDLE cycle, ends at the negedge of the IDLE cycle after DONE.
  task automatic do_access(input string name, input bit is_data, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rword, input logic [31:0] exp_addr);
    sb_item_t it;
    it.is_data = is_data;
    if (is_data && we) begin
      it.rdata = d_model;
    end else begin
      it.rdata = rword;
      if (is_data) d_model  = rword;
      else         if_model = rword;
    end
    sb.push_back(it);
    rd_mode = 1'b0;
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int k = 1; k <= int'(WAIT); k++) begin
      tick();
      rd_word = (k == int'(WAIT)) ? rword : ~rword;
      @(negedge clk);
      chk({name, "_en"}, {31'b0, sram_en}, 32'd1);
      chk({name, "_addr"}, 32'(sram_addr), exp_addr);
      chk({name, "_we"}, {31'b0, sram_we}, {31'b0, we});
      if (is_data && we) chk({name, "_wdata"}, sram_wdata, wdata);
    end
    tick();
    if_req = 1'b0;
    d_req  = 1'b0;
    rd_word = 32'hDEADBEEF;
    @(negedge clk);
    chk({name, "_done_en"}, {30'b0, sram_en, sram_we}, 32'd0);
    chk({name, "_ready"}, {30'b0, if_ready, d_ready}, is_data ? 32'd1 : 32'd2);
    tick();
    @(negedge clk);
    chk({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_addr_t;
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h4; d_addr = 32'h8; d_wdata = 32'h0;
    rd_mode = 1'b0; rd_word = 32'hDEADBEEF;
    if_model = '0; d_model = '0;

    // Reset with both requests high
    tick();
    tick();
    @(negedge clk);
    chk("rst_ctrl", {26'b0, sram_en, sram_we, busy, if_ready, d_ready, 1'b0}, 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    do_access("fetch", 1'b0, 1'b0, 32'h8, 32'h0, 32'h80010001, 32'd2);
    do_access("load", 1'b1, 1'b0, 32'hFFFF0007, 32'h0, 32'h12345678, 32'hC001);
    do_access("store", 1'b1, 1'b1, 32'd1024, 32'd1546, 32'h55555555, 32'd256);
    chk("store_if_rdata", if_rdata, 32'h80010001);
    chk("store_d_rdata", d_rdata, 32'h12345678);

    // Tie after reset: fetch wins, data follows one access period later
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    rd_mode = 1'b1;
    sb.push_back('{is_data: 1'b0, rdata: 32'hA5A50004});
    sb.push_back('{is_data: 1'b1, rdata: 32'hA5A50008});
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int c = 1; c <= 10; c++) begin
      tick();
      @(negedge clk);
      chk($sformatf("tie_c%0d_en", c), {31'b0, sram_en},
          ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)) ? 32'd1 : 32'd0);
      chk($sformatf("tie_c%0d_ready", c), {30'b0, if_ready, d_ready},
          (c == 4) ? 32'd2 : (c == 9) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 3) chk($sformatf("tie_c%0d_addr", c), 32'(sram_addr), 32'd4);
      if (c >= 6 && c <= 8) chk($sformatf("tie_c%0d_addr", c), 32'(sram_addr), 32'd8);
      if (c == 4) if_req = 1'b0;
      if (c == 9) d_req = 1'b0;
    end

    // Sustained contention: six accesses, strictly alternating starting with fetch
    n_if = 0; n_d = 0;
    if_addr = 32'h100; d_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      exp_addr_t = (i % 2 == 0) ? 32'hA5A50040 : 32'hA5A50080;
      sb.push_back('{is_data: bit'(i % 2), rdata: exp_addr_t});
    end
    if_req = 1'b1; d_req = 1'b1;
    repeat (30) tick();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("cont_pending", 32'(sb.size()), 32'd0);
    chk("cont_n_if", 32'(n_if), 32'd3);
    chk("cont_n_d", 32'(n_d), 32'd3);
    chk("cont_idle_busy", {31'b0, busy}, 32'd0);
    if_model = 32'hA5A50040;
    d_model  = 32'hA5A50080;

    // Reset during the second ACCESS cycle of a load
    rd_mode = 1'b0; rd_word = 32'h77777777;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_en", {31'b0, sram_en}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_d_rdata", d_rdata, 32'd0);
    chk("midrst_if_rdata", if_rdata, 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      chk($sformatf("midrst_quiet%0d", c), {29'b0, sram_en, if_ready, d_ready}, 32'd0);
    end
    if_model = '0; d_model = '0;

    do_access("refetch", 1'b0, 1'b0, 32'h4, 32'h0, 32'h0BADF00D, 32'd1);
    chk("final_pending", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
